// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared FP32 field constants, state encodings and clogb2 for the argmax block
package fc_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to hold indices 0..n-1; never less than one bit.
  function automatic int clogb2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if (((n - 1) >> i) != 0) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// rtl/fp32_gt.sv - combinational FP32 strict greater-than with NaN-aware ordering
module fp32_gt
  import fc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  logic        w_a_nan;
  logic        w_b_nan;
  logic [30:0] w_a_mag;
  logic [30:0] w_b_mag;

  assign w_a_nan = (&a[EXP_MSB:EXP_LSB]) && (|a[MAN_MSB:0]);
  assign w_b_nan = (&b[EXP_MSB:EXP_LSB]) && (|b[MAN_MSB:0]);
  assign w_a_mag = a[EXP_MSB:0];
  assign w_b_mag = b[EXP_MSB:0];

  // NaN never wins but always loses; +/-0 are equal; otherwise sign-magnitude order
  always_comb begin
    a_gt_b = 1'b0;
    if (w_a_nan) begin
      a_gt_b = 1'b0;
    end else if (w_b_nan) begin
      a_gt_b = 1'b1;
    end else if ((w_a_mag == 31'd0) && (w_b_mag == 31'd0)) begin
      a_gt_b = 1'b0;
    end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
      a_gt_b = ~a[SIGN_BIT];
    end else if (!a[SIGN_BIT]) begin
      a_gt_b = (w_a_mag > w_b_mag);
    end else begin
      a_gt_b = (w_a_mag < w_b_mag);
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - streaming argmax over one frame of FP32 fully-connected outputs
module fc_argmax
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          ready_in,
  output logic [clogb2(NUM_CLASSES)-1:0] class_out,
  output logic [DATA_WIDTH-1:0]         max_out,
  output logic                          valid_out,
  input  logic                          ack,
  output logic                          drop
);

  localparam int            CW   = clogb2(NUM_CLASSES);
  localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_class;
  logic [DATA_WIDTH-1:0] r_max;
  logic                  r_valid;
  logic                  r_ready;
  logic                  r_drop;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_gt;

  assign w_accept = valid_in && r_ready;
  assign w_last   = (r_cnt == LAST);

  fp32_gt u_gt (
    .a      (data_in),
    .b      (r_max),
    .a_gt_b (w_gt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: first feature opens a frame, last one closes it, ack releases the result
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_accept && w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: running best, feature counter, registered handshake outputs and sticky drop
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_cnt   <= '0;
      r_class <= '0;
      r_max   <= FP32_ZERO;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_drop  <= 1'b0;
    end else begin
      r_ready <= (w_next != ST_DONE);
      r_valid <= (w_next == ST_DONE);
      if (valid_in && !r_ready) begin
        r_drop <= 1'b1;
      end
      if (w_accept) begin
        if (r_state == ST_IDLE) begin
          r_class <= '0;
          r_max   <= data_in;
          r_cnt   <= CW'(1);
        end else if (r_state == ST_ACCUM) begin
          if (w_gt) begin
            r_class <= r_cnt;
            r_max   <= data_in;
          end
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
      end
    end
  end

  assign ready_in  = r_ready;
  assign valid_out = r_valid;
  assign class_out = r_class;
  assign max_out   = r_max;
  assign drop      = r_drop;

endmodule

// File: tb/tb_fc_argmax.sv
// tb/tb_fc_argmax.sv - directed self-checking bench for fc_argmax with NUM_CLASSES = 4
module tb_fc_argmax;

  localparam int NC = 4;

  logic        clk;
  logic        resetn;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_in;
  logic [1:0]  class_out;
  logic [31:0] max_out;
  logic        valid_out;
  logic        ack;
  logic        drop;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rise   = 0;
  logic prev_v = 1'b0;

  fc_argmax #(.NUM_CLASSES(NC), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .class_out (class_out),
    .max_out   (max_out),
    .valid_out (valid_out),
    .ack       (ack),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges of valid_out
  always @(posedge clk) begin
    prev_v <= valid_out;
    if (valid_out && !prev_v) begin
      n_rise <= n_rise + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    valid_in = 1'b1;
    data_in  = d;
    step();
    valid_in = 1'b0;
    data_in  = 32'h0;
    repeat (gap) step();
  endtask

  task automatic frame(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3,
                       input logic [1:0] exp_cls, input logic [31:0] exp_max);
    send(d0, 0);
    send(d1, 0);
    send(d2, 0);
    check({tag, ".valid_before_last"}, 32'(valid_out), 32'd0);
    send(d3, 0);
    check({tag, ".valid"}, 32'(valid_out), 32'd1);
    check({tag, ".ready"}, 32'(ready_in), 32'd0);
    check({tag, ".class"}, 32'(class_out), 32'(exp_cls));
    check({tag, ".max"}, max_out, exp_max);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, ".ack_valid"}, 32'(valid_out), 32'd0);
    check({tag, ".ack_ready"}, 32'(ready_in), 32'd1);
  endtask

  initial begin
    int rise0;
    logic [31:0] hold_max;
    logic [1:0]  hold_cls;

    resetn   = 1'b1;
    valid_in = 1'b0;
    data_in  = 32'h0;
    ack      = 1'b0;
    step();
    step();
    resetn = 1'b0;
    check("rst.ready", 32'(ready_in), 32'd1);
    check("rst.valid", 32'(valid_out), 32'd0);
    check("rst.class", 32'(class_out), 32'd0);
    check("rst.max", max_out, 32'h0);
    check("rst.drop", 32'(drop), 32'd0);

    frame("pos", 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000, 2'd1, 32'h40000000);
    do_ack("pos");

    frame("neg", 32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0800000, 2'd1, 32'hBF800000);
    do_ack("neg");

    frame("zero", 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 2'd0, 32'h80000000);
    do_ack("zero");

    frame("nan", 32'h7FC00000, 32'h3F000000, 32'h7FC00000, 32'h3E800000, 2'd1, 32'h3F000000);
    do_ack("nan");

    frame("denorm", 32'h00000001, 32'h00000003, 32'h00000002, 32'h80000005, 2'd1, 32'h00000003);
    do_ack("denorm");

    // Infinities with gaps inside the frame and a stray ack outside DONE
    send(32'hFF800000, 3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("gap.ack_ignored_valid", 32'(valid_out), 32'd0);
    send(32'h7F800000, 2);
    send(32'h7F800000, 0);
    check("gap.valid_early", 32'(valid_out), 32'd0);
    send(32'h00000001, 0);
    check("gap.valid", 32'(valid_out), 32'd1);
    check("gap.class", 32'(class_out), 32'd1);
    check("gap.max", max_out, 32'h7F800000);
    check("gap.drop_clear", 32'(drop), 32'd0);

    // Hold in DONE with ack low while a feature is pushed
    hold_cls = class_out;
    hold_max = max_out;
    for (int i = 0; i < 5; i++) begin
      valid_in = (i == 2);
      data_in  = 32'h7F7FFFFF;
      step();
      check("hold.valid", 32'(valid_out), 32'd1);
      check("hold.class", 32'(class_out), 32'd1);
      check("hold.max", max_out, 32'h7F800000);
    end
    valid_in = 1'b0;
    check("hold.drop", 32'(drop), 32'd1);
    do_ack("hold");
    check("hold.drop_sticky", 32'(drop), 32'd1);
    check("hold.snapshot", {30'd0, hold_cls} ^ hold_max, {30'd0, 2'd1} ^ 32'h7F800000);

    // Reset mid-frame, then a full new frame
    rise0 = n_rise;
    send(32'h42000000, 0);
    send(32'h42800000, 0);
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    check("mrst.valid", 32'(valid_out), 32'd0);
    check("mrst.drop", 32'(drop), 32'd0);
    check("mrst.ready", 32'(ready_in), 32'd1);
    frame("mrst", 32'h3F800000, 32'h3F000000, 32'h40400000, 32'h3E000000, 2'd2, 32'h40400000);
    do_ack("mrst");
    step();
    step();
    check("mrst.pulses", 32'(n_rise - rise0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: number of FC output features per classification frame (2..1024).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: IEEE-754 single-precision word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1: synchronous, active-high reset (asserted = 1).
REQ-005 SHALL have port valid_in, input, 1: data_in carries one FC feature this cycle; driven by the full_connected_16 valid_out.
REQ-006 SHALL have port data_in, input, 32: FP32 feature from the fully-connected stage.
REQ-007 SHALL have port ready_in, output, 1: block can accept a feature this cycle.
REQ-008 SHALL have port class_out, output, clogb2(NUM_CLASSES): index of the winning feature, 0-based in arrival order.
REQ-009 SHALL have port max_out, output, 32: FP32 value of the winning feature.
REQ-010 SHALL have port valid_out, output, 1: class_out and max_out are valid.
REQ-011 SHALL have port ack, input, 1: downstream has consumed the result.
REQ-012 SHALL have port drop, output, 1: sticky flag, set when valid_in arrives while ready_in = 0.

Function
REQ-013 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-014 IDLE: ready_in = 1; an accepted feature SHALL load the best register with index 0 and value data_in, set cnt = 1, and move to ACCUM (to DONE directly if NUM_CLASSES = 1 were allowed; it is not).
REQ-015 ACCUM: each accepted feature with index cnt SHALL replace best only if it is strictly greater than the stored value under REQ-018; cnt SHALL increment by 1.
REQ-016 ACCUM: acceptance of the feature with index NUM_CLASSES-1 SHALL move to DONE and reset cnt to 0; valid_out SHALL rise on the next cycle (latency 1 clk after the last accepted feature).
REQ-017 DONE: ready_in = 0, valid_out = 1, and class_out/max_out SHALL stay stable until ack = 1; on ack the FSM SHALL return to IDLE with valid_out = 0 on the next cycle.
REQ-018 Compare SHALL use sign-magnitude FP32 ordering: -0 equals +0; any NaN (exp = 0xFF, mantissa != 0) SHALL never replace best and SHALL lose to any non-NaN value; if the stored best is NaN, the next non-NaN value SHALL replace it; +/-Inf SHALL be ordered normally; denormals SHALL be compared by bit pattern.
REQ-019 Ties (equal values) SHALL keep the lower index.
REQ-020 valid_in with ready_in = 0 SHALL be ignored and SHALL set drop; drop SHALL clear only on reset.
REQ-021 valid_in gaps of any length inside a frame SHALL be tolerated; there SHALL be no timeout.
REQ-022 ack outside DONE SHALL be ignored.
REQ-023 ready_in SHALL be a registered function of the state, with no combinational path from ack or valid_in.

Reset
REQ-024 On resetn = 1 at a clock edge: state = IDLE, cnt = 0, class_out = 0, max_out = 0x00000000, valid_out = 0, drop = 0, ready_in = 1 from the next cycle.
REQ-025 Reset during ACCUM or DONE SHALL discard the partial or pending result; no valid_out pulse SHALL follow.

Structure
REQ-026 A shared package fc_pkg SHALL hold: the clogb2 function, FP32 field constants (SIGN_BIT = 31, EXP_MSB = 30, EXP_LSB = 23, MAN_MSB = 22), the FP32_ZERO constant, and the state encodings.
REQ-027 The comparator SHALL be one combinational sub-module fp32_gt (inputs a, b; output a_gt_b per REQ-018, including NaN rules); everything else stays in fc_argmax.

Verification
REQ-028 The NUM_CLASSES = 4 frame 0x3F800000, 0x40000000, 0xBF800000, 0x3F000000 SHALL produce class_out = 1 and max_out = 0x40000000 one clk after the 4th valid_in.
REQ-029 The frame 0xC0400000, 0xBF800000, 0xC0000000, 0xC0800000 (all negative) SHALL produce class_out = 1 and max_out = 0xBF800000.
REQ-030 The frame 0x80000000, 0x00000000, 0x80000000, 0x00000000 SHALL produce class_out = 0 (tie keeps the lower index, -0 equals +0).
REQ-031 The frame 0x7FC00000, 0x3F000000, 0x7FC00000, 0x3E800000 SHALL produce class_out = 1 and max_out = 0x3F000000.
REQ-032 Holding ack = 0 for 5 clks and driving valid_in during DONE SHALL keep outputs stable and set drop = 1; ack SHALL then give valid_out = 0 and ready_in = 1 on the next cycle.
REQ-033 resetn = 1 after 2 of 4 features, followed by a full new frame, SHALL produce exactly one valid_out whose result reflects only the new frame.
